// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the stall-model pipeline sequencer.
// State encoding, scoreboard slot layout and a slot match helper.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    STALL   = 2'd1,
    MEMWAIT = 2'd2
  } state_e;

  localparam logic [4:0] REG_X0 = 5'd0;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
  } sb_slot_t;

  function automatic logic slot_hit(
    input sb_slot_t   s,
    input logic [4:0] r
  );
    return s.valid && (s.rd == r);
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// ID-stage hazard request and pipeline register control bundle.
// master = core datapath side, slave = hazard_ctrl.
interface hazard_ctrl_if;
  logic [4:0] rs1_id;
  logic [4:0] rs2_id;
  logic       use_rs1;
  logic       use_rs2;
  logic [4:0] rd_id;
  logic       regwen_id;
  logic       br_taken_ex;
  logic       mem_busy;
  logic       pc_en;
  logic       if_id_en;
  logic       if_id_flush;
  logic       id_ex_en;
  logic       id_ex_flush;
  logic       ex_mem_en;
  logic       ex_mem_flush;

  modport master (
    output rs1_id, rs2_id, use_rs1, use_rs2,
    output rd_id, regwen_id, br_taken_ex, mem_busy,
    input  pc_en, if_id_en, if_id_flush,
    input  id_ex_en, id_ex_flush,
    input  ex_mem_en, ex_mem_flush
  );

  modport slave (
    input  rs1_id, rs2_id, use_rs1, use_rs2,
    input  rd_id, regwen_id, br_taken_ex, mem_busy,
    output pc_en, if_id_en, if_id_flush,
    output id_ex_en, id_ex_flush,
    output ex_mem_en, ex_mem_flush
  );
endinterface

// File: rtl/hazard_ctrl_scoreboard.sv
// Shadow of in-flight destinations (EX, MEM, WB) and RAW detect.
// x0 never forms a slot nor a match.
module hazard_scoreboard
  import hazard_ctrl_pkg::*;
#(
  parameter int WB_WRITE_FIRST = 1
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [4:0] rs1_i,
  input  logic [4:0] rs2_i,
  input  logic       use_rs1_i,
  input  logic       use_rs2_i,
  input  logic [4:0] rd_i,
  input  logic       regwen_i,
  input  logic       adv_i,
  input  logic       bubble_i,
  output logic       raw_o
);

  localparam logic WB_CHK = (WB_WRITE_FIRST == 0);

  sb_slot_t ex_q, mem_q, wb_q;
  sb_slot_t ex_d, mem_d, wb_d;
  logic     hit1, hit2;

  always_comb begin
    ex_d  = ex_q;
    mem_d = mem_q;
    wb_d  = wb_q;
    if (adv_i) begin
      wb_d     = mem_q;
      mem_d    = ex_q;
      ex_d     = '0;
      if (!bubble_i) begin
        ex_d.valid = regwen_i && (rd_i != REG_X0);
        ex_d.rd    = rd_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
    end
  end

  assign hit1 = (rs1_i != REG_X0)
             && (slot_hit(ex_q, rs1_i)
              || slot_hit(mem_q, rs1_i)
              || (WB_CHK && slot_hit(wb_q, rs1_i)));
  assign hit2 = (rs2_i != REG_X0)
             && (slot_hit(ex_q, rs2_i)
              || slot_hit(mem_q, rs2_i)
              || (WB_CHK && slot_hit(wb_q, rs2_i)));

  assign raw_o = (use_rs1_i && hit1) || (use_rs2_i && hit2);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer: RAW stall, branch flush, memory freeze.
// Also keeps saturating stall/flush event counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int WB_WRITE_FIRST = 1,
  parameter int CNT_W          = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  hazard_ctrl_if.slave     hz,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             raw;
  logic             do_flush;
  logic             do_stall;

  hazard_scoreboard #(
    .WB_WRITE_FIRST(WB_WRITE_FIRST)
  ) u_sb (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .rs1_i    (hz.rs1_id),
    .rs2_i    (hz.rs2_id),
    .use_rs1_i(hz.use_rs1),
    .use_rs2_i(hz.use_rs2),
    .rd_i     (hz.rd_id),
    .regwen_i (hz.regwen_id),
    .adv_i    (!hz.mem_busy),
    .bubble_i (hz.br_taken_ex || raw),
    .raw_o    (raw)
  );

  // A taken branch outranks raw: the ID instruction is wrong-path.
  assign do_flush = !hz.mem_busy && hz.br_taken_ex;
  assign do_stall = !hz.mem_busy && !hz.br_taken_ex && raw;

  always_comb begin
    hz.pc_en       = 1'b1;
    hz.if_id_en    = 1'b1;
    hz.if_id_flush = 1'b0;
    hz.id_ex_en    = 1'b1;
    hz.id_ex_flush = 1'b0;
    hz.ex_mem_en   = 1'b1;
    state_d        = RUN;
    unique case (1'b1)
      hz.mem_busy: begin
        hz.pc_en     = 1'b0;
        hz.if_id_en  = 1'b0;
        hz.id_ex_en  = 1'b0;
        hz.ex_mem_en = 1'b0;
        state_d      = MEMWAIT;
      end
      do_flush: begin
        hz.if_id_flush = 1'b1;
        hz.id_ex_flush = 1'b1;
      end
      do_stall: begin
        hz.pc_en       = 1'b0;
        hz.if_id_en    = 1'b0;
        hz.id_ex_flush = 1'b1;
        state_d        = STALL;
      end
      default: ;
    endcase
  end

  assign hz.ex_mem_flush = 1'b0;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (do_stall && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (do_flush && (flush_cnt_q != '1))
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= RUN;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign state_o     = state_q;
  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: default build (a)
// and a WB-hazard, 4-bit-counter build (b).
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

  // {pc_en, if_id_en, if_id_flush, id_ex_en,
  //  id_ex_flush, ex_mem_en, ex_mem_flush}
  localparam logic [6:0] NORM = 7'b1101010;
  localparam logic [6:0] STL  = 7'b0001110;
  localparam logic [6:0] FLS  = 7'b1111110;
  localparam logic [6:0] FRZ  = 7'b0000000;
  localparam logic [1:0] S_RUN = 2'd0;
  localparam logic [1:0] S_STL = 2'd1;
  localparam logic [1:0] S_MW  = 2'd2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int          errs = 0;
  int          checks = 0;

  hazard_ctrl_if ifa ();
  hazard_ctrl_if ifb ();

  logic [1:0]  st_a, st_b;
  logic [15:0] sc_a, fc_a;
  logic [3:0]  sc_b, fc_b;
  wire  [6:0]  ctl_a = {ifa.pc_en, ifa.if_id_en,
                        ifa.if_id_flush, ifa.id_ex_en,
                        ifa.id_ex_flush, ifa.ex_mem_en,
                        ifa.ex_mem_flush};
  wire  [6:0]  ctl_b = {ifb.pc_en, ifb.if_id_en,
                        ifb.if_id_flush, ifb.id_ex_en,
                        ifb.id_ex_flush, ifb.ex_mem_en,
                        ifb.ex_mem_flush};

  always #5 clk = ~clk;

  hazard_ctrl dut_a (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .hz         (ifa),
    .state_o    (st_a),
    .stall_cnt_o(sc_a),
    .flush_cnt_o(fc_a)
  );

  hazard_ctrl #(
    .WB_WRITE_FIRST(0),
    .CNT_W         (4)
  ) dut_b (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .hz         (ifb),
    .state_o    (st_b),
    .stall_cnt_o(sc_b),
    .flush_cnt_o(fc_b)
  );

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(
    input bit         b,
    input logic [4:0] r1, r2,
    input logic       u1, u2,
    input logic [4:0] rd,
    input logic       wen, br, busy
  );
    {ifa.rs1_id, ifa.rs2_id, ifa.use_rs1, ifa.use_rs2} = '0;
    {ifa.rd_id, ifa.regwen_id, ifa.br_taken_ex} = '0;
    ifa.mem_busy = 1'b0;
    {ifb.rs1_id, ifb.rs2_id, ifb.use_rs1, ifb.use_rs2} = '0;
    {ifb.rd_id, ifb.regwen_id, ifb.br_taken_ex} = '0;
    ifb.mem_busy = 1'b0;
    if (!b) begin
      ifa.rs1_id = r1; ifa.rs2_id = r2;
      ifa.use_rs1 = u1; ifa.use_rs2 = u2;
      ifa.rd_id = rd; ifa.regwen_id = wen;
      ifa.br_taken_ex = br; ifa.mem_busy = busy;
    end else begin
      ifb.rs1_id = r1; ifb.rs2_id = r2;
      ifb.use_rs1 = u1; ifb.use_rs2 = u2;
      ifb.rd_id = rd; ifb.regwen_id = wen;
      ifb.br_taken_ex = br; ifb.mem_busy = busy;
    end
  endtask

  // Called at posedge+1; checks controls mid-cycle, state after edge.
  task automatic step(
    input string      tag,
    input bit         b,
    input logic [4:0] r1, r2,
    input logic       u1, u2,
    input logic [4:0] rd,
    input logic       wen, br, busy,
    input logic [6:0] ectl,
    input logic [1:0] est
  );
    drive(b, r1, r2, u1, u2, rd, wen, br, busy);
    #2;
    check({tag, ".ctl"}, b ? ctl_b : ctl_a, ectl);
    @(posedge clk);
    #1;
    check({tag, ".st"}, b ? st_b : st_a, est);
  endtask

  task automatic nops(input bit b, input int n);
    for (int i = 0; i < n; i++)
      step("nop", b, 0, 0, 0, 0, 0, 0, 0, 0, NORM, S_RUN);
  endtask

  task automatic pair_b(input logic [6:0] ectl_s);
    step("b.prod", 1, 1, 2, 1, 1, 5, 1, 0, 0, NORM, S_RUN);
    for (int i = 0; i < 3; i++)
      step("b.stl", 1, 5, 0, 1, 0, 0, 0, 0, 0, ectl_s, S_STL);
    step("b.iss", 1, 5, 0, 1, 0, 0, 0, 0, 0, NORM, S_RUN);
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check("rst.ctl_a", ctl_a, NORM);
    check("rst.st_a", st_a, S_RUN);
    check("rst.sc_a", sc_a, 0);
    check("rst.fc_a", fc_a, 0);
    check("rst.ctl_b", ctl_b, NORM);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // independent back-to-back ALU ops
    for (int i = 0; i < 3; i++)
      step("indep", 0, 1, 2, 1, 1, 5, 1, 0, 0, NORM, S_RUN);
    check("indep.sc", sc_a, 0);
    nops(0, 3);

    // RAW on rs1, two stall cycles
    step("raw.prod", 0, 1, 2, 1, 1, 5, 1, 0, 0, NORM, S_RUN);
    step("raw.s1", 0, 5, 0, 1, 0, 6, 1, 0, 0, STL, S_STL);
    step("raw.s2", 0, 5, 0, 1, 0, 6, 1, 0, 0, STL, S_STL);
    step("raw.iss", 0, 5, 0, 1, 0, 6, 1, 0, 0, NORM, S_RUN);
    check("raw.sc", sc_a, 2);
    nops(0, 3);

    // x0 never hazards
    step("x0.prod", 0, 1, 2, 1, 1, 0, 1, 0, 0, NORM, S_RUN);
    step("x0.cons", 0, 0, 0, 1, 1, 0, 1, 0, 0, NORM, S_RUN);
    check("x0.sc", sc_a, 2);
    nops(0, 2);

    // branch flush wins over pending RAW
    step("br.prod", 0, 1, 2, 1, 1, 7, 1, 0, 0, NORM, S_RUN);
    step("br.fl", 0, 7, 0, 1, 0, 0, 0, 1, 0, FLS, S_RUN);
    check("br.fc", fc_a, 1);
    check("br.sc", sc_a, 2);
    step("br.tgt", 0, 7, 0, 1, 0, 0, 0, 0, 0, STL, S_STL);
    step("br.iss", 0, 7, 0, 1, 0, 0, 0, 0, 0, NORM, S_RUN);
    check("br.sc2", sc_a, 3);
    nops(0, 3);

    // memory freeze during a RAW stall
    step("mw.prod", 0, 1, 2, 1, 1, 8, 1, 0, 0, NORM, S_RUN);
    step("mw.s1", 0, 0, 8, 0, 1, 0, 0, 0, 0, STL, S_STL);
    check("mw.sc1", sc_a, 4);
    for (int i = 0; i < 4; i++)
      step("mw.frz", 0, 0, 8, 0, 1, 0, 0, 0, 1, FRZ, S_MW);
    check("mw.sc2", sc_a, 4);
    step("mw.s2", 0, 0, 8, 0, 1, 0, 0, 0, 0, STL, S_STL);
    step("mw.iss", 0, 0, 8, 0, 1, 0, 0, 0, 0, NORM, S_RUN);
    check("mw.sc3", sc_a, 5);
    nops(0, 3);

    // freeze beats branch; branch replays after
    step("bf.frz", 0, 0, 0, 0, 0, 0, 0, 1, 1, FRZ, S_MW);
    check("bf.fc1", fc_a, 1);
    step("bf.fl", 0, 0, 0, 0, 0, 0, 0, 1, 0, FLS, S_RUN);
    check("bf.fc2", fc_a, 2);
    nops(0, 3);

    // build b: WB is a hazard source, 4-bit counters
    pair_b(STL);
    check("b.sc3", sc_b, 3);
    for (int k = 0; k < 4; k++) pair_b(STL);
    check("b.sc15", sc_b, 15);
    pair_b(STL);
    check("b.sat", sc_b, 15);
    nops(1, 2);

    // async reset mid-stall
    step("ar.prod", 0, 1, 2, 1, 1, 9, 1, 0, 0, NORM, S_RUN);
    drive(0, 9, 0, 1, 0, 0, 0, 0, 0);
    #2;
    check("ar.stl", ctl_a, STL);
    rst_n = 1'b0;
    #1;
    check("ar.ctl", ctl_a, NORM);
    check("ar.st", st_a, S_RUN);
    check("ar.sc", sc_a, 0);
    check("ar.fc", fc_a, 0);
    check("ar.scb", sc_b, 0);
    @(posedge clk);
    #1;
    check("ar.st2", st_a, S_RUN);
    rst_n = 1'b1;
    step("ar.iss", 0, 9, 0, 1, 0, 0, 0, 0, 0, NORM, S_RUN);
    check("ar.sc2", sc_a, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline sequencer for the stall-model RV32I core, which has no forwarding.
- Drives the enable/reset (stall/flush) inputs of the IF/ID, ID/EX and EX/MEM stage registers and the PC enable.
- Keeps a shadow scoreboard of in-flight destination registers (EX, MEM, WB) and stalls decode on read-after-write hazards.
- Flushes wrong-path instructions on a taken branch/jump resolved in EX, freezes the whole pipe on a data-memory wait, and counts stall/flush events.

Parameters:
- WB_WRITE_FIRST, 1, 1 = register file writes in the first half-cycle, so the WB stage never causes a hazard; 0 = WB is a hazard source.
- CNT_W, 16, width of the saturating performance counters.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- rs1_id_i  in  5  ID-stage source register 1
- rs2_id_i  in  5  ID-stage source register 2
- use_rs1_i  in  1  ID instruction reads rs1
- use_rs2_i  in  1  ID instruction reads rs2
- rd_id_i  in  5  ID-stage destination register
- regwen_id_i  in  1  ID instruction writes rd
- br_taken_ex_i  in  1  branch/jump in EX redirects PC this cycle
- mem_busy_i  in  1  data memory not ready; hold all stages
- pc_en_o  out  1  PC register enable
- if_id_en_o  out  1  IF/ID enable
- if_id_flush_o  out  1  IF/ID synchronous clear (valid only with enable)
- id_ex_en_o  out  1  ID/EX enable
- id_ex_flush_o  out  1  ID/EX clear (inserts bubble)
- ex_mem_en_o  out  1  EX/MEM enable
- ex_mem_flush_o  out  1  EX/MEM clear; always 0, reserved
- state_o  out  2  FSM state (0 RUN, 1 STALL, 2 MEMWAIT)
- stall_cnt_o  out  CNT_W  RAW-stall cycle count, saturating
- flush_cnt_o  out  CNT_W  taken-branch flush count, saturating

Behaviour:
- Reset: scoreboard entries invalid, state RUN, counters 0. With mem_busy_i=0 the outputs settle to all enables 1, all flushes 0.
- Scoreboard: three slots {valid, rd} for EX, MEM, WB.
  - A slot is valid only when regwen=1 and rd≠0; x0 is never a hazard.
  - On each advancing cycle: WB←MEM, MEM←EX, and EX←{regwen_id_i && rd≠0, rd_id_i}, or invalid when a bubble or flush enters ID/EX.
- raw: (use_rs1_i && rs1_id_i≠0 && rs1_id_i matches a valid slot) OR (the same for rs2).
  - Slots checked: EX and MEM; WB is included only when WB_WRITE_FIRST=0.
- Priority per cycle, combinational outputs:
  1. mem_busy_i: all enables 0, flushes 0, scoreboard frozen, state→MEMWAIT.
  2. br_taken_ex_i: all enables 1, if_id_flush_o=1, id_ex_flush_o=1, scoreboard shifts in a bubble, flush_cnt_o+1, state→RUN. A pending raw is ignored because the ID instruction is wrong-path.
  3. raw: pc_en_o=0, if_id_en_o=0, id_ex_en_o=1 with id_ex_flush_o=1 (bubble), ex_mem_en_o=1, scoreboard shifts in a bubble, stall_cnt_o+1, state→STALL.
  4. Otherwise: all enables 1, flushes 0, normal shift, state→RUN.
- Latency: a dependent instruction directly behind its producer stalls 2 cycles (3 when WB_WRITE_FIRST=0). It issues on the cycle the producer leaves the last checked slot.
- MEMWAIT exit: on the first cycle mem_busy_i=0, the normal priority rules are re-evaluated on the unchanged scoreboard. There is no extra cycle.
- Counters saturate at all-ones and hold; they do not wrap.
- rst_ni deassertion mid-operation: everything returns to reset values immediately (asynchronous). In-flight entries are discarded.
- Simultaneous br_taken_ex_i and mem_busy_i: the freeze wins. The branch stays in EX and is reprocessed when mem_busy_i drops.

Decomposition:
- Shared package (core pkg):
  - state enum {RUN, STALL, MEMWAIT};
  - constant REG_X0 = 5'd0;
  - scoreboard slot struct {logic valid; logic [4:0] rd;}.
- One natural sub-module, hazard_scoreboard: the 3-slot shift register plus match logic, outputting raw.
- The FSM and counters remain in hazard_ctrl.

Test Plan:
- Reset, then back-to-back independent ALU instructions (rd=5, rs=1/2) → every cycle all enables 1, flushes 0, state_o=0, stall_cnt_o=0.
- add x5; next instruction reads rs1=5 (WB_WRITE_FIRST=1) → pc_en_o/if_id_en_o=0 and id_ex_flush_o=1 for exactly 2 cycles, stall_cnt_o=2, then normal issue. With WB_WRITE_FIRST=0 → 3 cycles.
- Producer writes x0, consumer reads x0 → no stall.
- br_taken_ex_i pulse while ID holds a RAW-dependent instruction → if_id_flush_o=id_ex_flush_o=1 for 1 cycle, no stall, flush_cnt_o=1.
- mem_busy_i held 4 cycles during a RAW stall → all enables 0 and state_o=2 for 4 cycles, stall_cnt_o unchanged; stall resumes afterwards with the correct remaining count.
- Force stall_cnt_o to 16'hFFFF via repeated stalls (CNT_W=4 build: 15 stalls) → counter holds at max. Assert rst_ni low mid-stall → outputs return to reset values asynchronously.
